io_bridge: RTL and testbench

Parametrised board-side I/O conditioning block for the FPGA emulator, sitting between the board pins/PLL and the ASIC `top`. It synchronises `DATA_W` data and `CTRL_W` control inputs through a configurable-depth synchroniser and filters `N_SW` switches with per-switch counter debouncers. A lock-aware reset sequencer releases the core reset only after a programmable hold and re-asserts it on PLL lock loss. Core outputs get a single, optionally reset-gated, output register stage before the pin buffers.

---
 rtl/io_bridge_pkg.sv | 24 ++
 rtl/io_bridge_switch_filter.sv | 40 ++++
 rtl/io_bridge.sv | 144 ++++++++++++++
 tb/tb_io_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the io_bridge block
// Contents: reset-sequencer state encoding, lock-loss counter width and
// saturation value, saturating increment helper. No ports.
package io_bridge_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  typedef enum logic [1:0] {
    WAIT_LOCK = ST_WAIT_LOCK,
    HOLD      = ST_HOLD,
    RUN       = ST_RUN
  } seq_state_e;

  localparam int                 LOSS_W   = 8;
  localparam logic [LOSS_W-1:0]  LOSS_SAT = 8'hFF;

  // Counter sticks at LOSS_SAT instead of wrapping back to zero.
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == LOSS_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/io_bridge_switch_filter.sv
// rtl/io_bridge_switch_filter.sv - counter debouncer for one synchronised switch
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   sw_s_i   in  switch level, already synchronised to clk
//   sw_o     out debounced switch level
module switch_filter #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_s_i,
  output logic sw_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out;

  // The counter measures how long the input has disagreed with the output;
  // any agreement (a bounce back) restarts the measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (sw_s_i == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_out <= ~r_out;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sw_o = r_out;

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - board-side I/O conditioning: synchronisers, switch debounce, lock-aware core reset, output register
// Ports:
//   clk             in  single clock for all logic
//   rst_n           in  asynchronous active-low reset
//   pll_lock_i      in  asynchronous PLL lock
//   data_i          in  asynchronous data pins        -> data_o  (synchronised)
//   ctrl_i          in  asynchronous control pins     -> ctrl_o  (synchronised)
//   sw_i            in  raw switches                  -> sw_o    (synchronised + debounced)
//   core_out_i      in  core outputs                  -> out_o   (registered, reset-gated)
//   core_rst_n_o    out core active-low reset, high only while the sequencer is in RUN
//   lock_loss_cnt_o out saturating count of lock losses seen in HOLD or RUN
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int CTRL_W          = 5,
  parameter int OUT_W           = 10,
  parameter int N_SW            = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int RST_HOLD        = 4,
  parameter int OUT_GATE        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [N_SW-1:0]   sw_i,
  input  logic [OUT_W-1:0]  core_out_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [N_SW-1:0]   sw_o,
  output logic              core_rst_n_o,
  output logic [OUT_W-1:0]  out_o,
  output logic [7:0]        lock_loss_cnt_o
);

  localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  // Stage 0 takes the raw pin; stage SYNC_STAGES-1 is the usable value.
  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0][CTRL_W-1:0] r_ctrl_sync;
  logic [SYNC_STAGES-1:0][N_SW-1:0]   r_sw_sync;
  logic [SYNC_STAGES-1:0]             r_lock_sync;

  seq_state_e         r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_core_rst_n;
  logic [LOSS_W-1:0]  r_loss_cnt;
  logic [OUT_W-1:0]   r_out;
  logic               w_lock_s;
  logic [N_SW-1:0]    w_sw_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_sync <= '0;
      r_ctrl_sync <= '0;
      r_sw_sync   <= '0;
      r_lock_sync <= '0;
    end else begin
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_i};
      r_ctrl_sync <= {r_ctrl_sync[SYNC_STAGES-2:0], ctrl_i};
      r_sw_sync   <= {r_sw_sync[SYNC_STAGES-2:0], sw_i};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

  // Core reset is its own flop, set/cleared on the same edges as the state
  // transitions into/out of RUN, so it can never glitch from decode logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_core_rst_n <= 1'b0;
      r_loss_cnt   <= '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (!w_lock_s) begin
            r_state    <= WAIT_LOCK;
            r_loss_cnt <= sat_inc(r_loss_cnt);
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= RUN;
            r_core_rst_n <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state      <= WAIT_LOCK;
            r_core_rst_n <= 1'b0;
            r_loss_cnt   <= sat_inc(r_loss_cnt);
          end
        end
        default: begin
          r_state      <= WAIT_LOCK;
          r_core_rst_n <= 1'b0;
        end
      endcase
    end
  end

  // Gating uses the registered core reset, so the first ungated value is
  // captured on the edge after core_rst_n_o rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if ((OUT_GATE != 0) && !r_core_rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= core_out_i;
    end
  end

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    switch_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_switch_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_s_i (r_sw_sync[SYNC_STAGES-1][g]),
      .sw_o   (w_sw_db[g])
    );
  end

  assign data_o          = r_data_sync[SYNC_STAGES-1];
  assign ctrl_o          = r_ctrl_sync[SYNC_STAGES-1];
  assign sw_o            = w_sw_db;
  assign core_rst_n_o    = r_core_rst_n;
  assign out_o           = r_out;
  assign lock_loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - scoreboard bench for io_bridge with randomized stimulus
module tb_io_bridge;

  localparam int DATA_W = 8;
  localparam int CTRL_W = 5;
  localparam int OUT_W  = 10;
  localparam int N_SW   = 2;
  localparam int SYNC   = 2;
  localparam int DEB    = 8;
  localparam int HOLD   = 4;
  localparam int GATE   = 1;
  localparam int HN     = 16384;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pll_lock_i;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [N_SW-1:0]   sw_i;
  logic [OUT_W-1:0]  core_out_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [N_SW-1:0]   sw_o;
  logic              core_rst_n_o;
  logic [OUT_W-1:0]  out_o;
  logic [7:0]        lock_loss_cnt_o;

  always #5 clk = ~clk;

  io_bridge #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .OUT_W(OUT_W), .N_SW(N_SW),
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RST_HOLD(HOLD), .OUT_GATE(GATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .data_i(data_i),
    .ctrl_i(ctrl_i), .sw_i(sw_i), .core_out_i(core_out_i), .data_o(data_o),
    .ctrl_o(ctrl_o), .sw_o(sw_o), .core_rst_n_o(core_rst_n_o), .out_o(out_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic [N_SW-1:0]   s;
    logic              r;
    logic [OUT_W-1:0]  o;
    logic [7:0]        l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Input history indexed by clock edge; entries for edges under reset are 0.
  logic [DATA_W-1:0] h_data [HN];
  logic [CTRL_W-1:0] h_ctrl [HN];
  logic              h_lock [HN];
  logic [N_SW-1:0]   h_sw   [HN];
  int                k = 16;

  // Reference state: run length of consecutive high lock samples, previous
  // lock sample, loss events, per-switch debounced level and disagreement run.
  int               lock_run;
  logic             lock_prev;
  int               loss;
  logic             m_rst;
  logic [N_SW-1:0]  m_sw;
  int               sw_run [N_SW];
  logic [OUT_W-1:0] m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lock_run  = 0;
    lock_prev = 1'b0;
    loss      = 0;
    m_rst     = 1'b0;
    m_sw      = '0;
    m_out     = '0;
    for (int i = 0; i < N_SW; i++) sw_run[i] = 0;
  endtask

  task automatic model_edge();
    exp_t            e;
    logic            lock_s;
    logic [N_SW-1:0] s;
    if (!rst_n) begin
      for (int j = 0; j <= SYNC; j++) begin
        h_data[k-j] = '0; h_ctrl[k-j] = '0; h_lock[k-j] = 1'b0; h_sw[k-j] = '0;
      end
      model_reset();
      e = '0;
    end else begin
      h_data[k] = data_i;
      h_ctrl[k] = ctrl_i;
      h_lock[k] = pll_lock_i;
      h_sw[k]   = sw_i;
      m_out = (GATE != 0 && !m_rst) ? '0 : core_out_i;
      lock_s = h_lock[k-SYNC];
      if (lock_prev && !lock_s && loss < 255) loss++;
      lock_run  = lock_s ? lock_run + 1 : 0;
      lock_prev = lock_s;
      m_rst     = (lock_run >= HOLD + 1);
      s = h_sw[k-SYNC];
      for (int i = 0; i < N_SW; i++) begin
        if (s[i] == m_sw[i]) begin
          sw_run[i] = 0;
        end else begin
          sw_run[i]++;
          if (sw_run[i] == DEB) begin
            m_sw[i]   = ~m_sw[i];
            sw_run[i] = 0;
          end
        end
      end
      e.d = h_data[k-SYNC+1];
      e.c = h_ctrl[k-SYNC+1];
      e.s = m_sw;
      e.r = m_rst;
      e.o = m_out;
      e.l = loss[7:0];
    end
    k++;
    sb.push_back(e);
  endtask

  task automatic step(input logic lk, input logic [N_SW-1:0] sw, input logic rn,
                      input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic [OUT_W-1:0] o);
    @(negedge clk);
    rst_n      = rn;
    pll_lock_i = lk;
    sw_i       = sw;
    data_i     = d;
    ctrl_i     = c;
    core_out_i = o;
    if (!rn) begin
      #1;
      chk("rst_data_o", 32'(data_o), 32'd0);
      chk("rst_ctrl_o", 32'(ctrl_o), 32'd0);
      chk("rst_sw_o", 32'(sw_o), 32'd0);
      chk("rst_core_rst_n_o", 32'(core_rst_n_o), 32'd0);
      chk("rst_out_o", 32'(out_o), 32'd0);
      chk("rst_lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'd0);
    end
    model_edge();
  endtask

  task automatic rstep(input logic lk, input logic [N_SW-1:0] sw, input logic rn);
    step(lk, sw, rn, DATA_W'($urandom), CTRL_W'($urandom), OUT_W'($urandom));
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every posedge the oldest expectation is compared with the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data_o", 32'(data_o), 32'(e.d));
        chk("ctrl_o", 32'(ctrl_o), 32'(e.c));
        chk("sw_o", 32'(sw_o), 32'(e.s));
        chk("core_rst_n_o", 32'(core_rst_n_o), 32'(e.r));
        chk("out_o", 32'(out_o), 32'(e.o));
        chk("lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'(e.l));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int              first;
    int              mx;
    int              lrun;
    int              srun [N_SW];
    logic            lk;
    logic [N_SW-1:0] sw;

    rst_n = 1'b0; pll_lock_i = 1'b0; data_i = '0; ctrl_i = '0; sw_i = '0; core_out_i = '0;
    for (int i = 0; i < HN; i++) begin
      h_data[i] = '0; h_ctrl[i] = '0; h_lock[i] = 1'b0; h_sw[i] = '0;
    end
    model_reset();

    repeat (3) rstep(1'b0, '0, 1'b0);

    // Lock rising from reset: core reset released on the 7th edge.
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      rstep(1'b1, '0, 1'b1);
      sample();
      if (first < 0 && core_rst_n_o) first = n;
    end
    chk("lock_rise_latency", 32'(first), 32'd7);

    // Glitch during HOLD restarts the hold and counts one loss.
    repeat (2) rstep(1'b0, '0, 1'b0);
    repeat (3) rstep(1'b1, '0, 1'b1);
    rstep(1'b0, '0, 1'b1);
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      rstep(1'b1, '0, 1'b1);
      sample();
      if (first < 0 && core_rst_n_o) first = n;
    end
    chk("glitch_latency", 32'(first), 32'd7);
    chk("glitch_loss", 32'(lock_loss_cnt_o), 32'd1);

    // Data/control pass-through and ungated output while in RUN.
    step(1'b1, '0, 1'b1, 8'hA5, 5'h13, 10'h3FF);
    sample();
    chk("out_run", 32'(out_o), 32'h3FF);
    rstep(1'b1, '0, 1'b1);
    sample();
    chk("data_a5", 32'(data_o), 32'hA5);
    chk("ctrl_13", 32'(ctrl_o), 32'h13);

    // Lock drop in RUN: core reset low on the 3rd edge, output gated next.
    first = -1;
    for (int n = 1; n <= 10; n++) begin
      if (first < 0) begin
        rstep(1'b0, '0, 1'b1);
        sample();
        if (!core_rst_n_o) first = n;
      end
    end
    chk("lock_fall_latency", 32'(first), 32'd3);
    step(1'b0, '0, 1'b1, 8'h00, 5'h00, 10'h3FF);
    sample();
    chk("out_gated", 32'(out_o), 32'd0);

    // Switch: 7-cycle pulse is swallowed, 9-cycle hold shows after 10 edges.
    mx = 0;
    for (int n = 1; n <= 19; n++) begin
      rstep(1'b0, (n <= 7) ? 2'b10 : 2'b00, 1'b1);
      sample();
      if (sw_o[1]) mx = 1;
    end
    chk("sw_short_pulse", 32'(mx), 32'd0);
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      rstep(1'b0, (n <= 9) ? 2'b10 : 2'b00, 1'b1);
      sample();
      if (first < 0 && sw_o[1]) first = n;
    end
    chk("sw_hold_latency", 32'(first), 32'd10);
    repeat (12) rstep(1'b0, '0, 1'b1);

    // Reset in the middle of HOLD and of a debounce, then a clean restart.
    repeat (4) rstep(1'b1, 2'b01, 1'b1);
    rstep(1'b1, 2'b01, 1'b0);
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      rstep(1'b1, '0, 1'b1);
      sample();
      if (first < 0 && core_rst_n_o) first = n;
    end
    chk("post_reset_latency", 32'(first), 32'd7);

    // 300 lock drops saturate the loss counter.
    for (int n = 0; n < 600; n++) rstep(n[0] ? 1'b0 : 1'b1, '0, 1'b1);
    sample();
    chk("loss_saturate", 32'(lock_loss_cnt_o), 32'd255);

    // Randomized run-length traffic with occasional resets.
    lrun = 0; lk = 1'b0; sw = '0;
    for (int i = 0; i < N_SW; i++) srun[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      if (lrun == 0) begin
        lk   = ($urandom_range(0, 3) != 0);
        lrun = $urandom_range(1, 14);
      end
      lrun--;
      for (int b = 0; b < N_SW; b++) begin
        if (srun[b] == 0) begin
          sw[b]   = 1'($urandom_range(0, 1));
          srun[b] = $urandom_range(1, 12);
        end
        srun[b]--;
      end
      rstep(lk, sw, ($urandom_range(0, 299) != 0));
    end

    sample();
    sample();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
